// File: rtl/unidad_pc.sv
// Program counter unit: BOOT/RUN/TRAP sequencing, redirect and misaligned-target trap.
// Optional performance counters are compiled in with BRANCH_COUNTER_EN.
module unidad_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_pc_src,
    input  logic [31:0] branch_target,
    input  logic        pc_en,
    input  logic        trap_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned_trap,
    output logic [31:0] mtval
`ifdef BRANCH_COUNTER_EN
    ,
    output logic [31:0] taken_count,
    output logic [31:0] retired_count
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t state;

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= BOOT;
            pc              <= RESET_VECTOR;
            misaligned_trap <= 1'b0;
            mtval           <= 32'h0;
`ifdef BRANCH_COUNTER_EN
            taken_count     <= 32'h0;
            retired_count   <= 32'h0;
`endif
        end else begin
            case (state)
                // Let the instruction at the reset vector execute before advancing.
                BOOT: state <= RUN;
                RUN: begin
                    if (pc_en) begin
                        if (next_pc_src) begin
                            if (branch_target[1:0] == 2'b00) begin
                                pc <= branch_target;
`ifdef BRANCH_COUNTER_EN
                                taken_count   <= taken_count + 32'd1;
                                retired_count <= retired_count + 32'd1;
`endif
                            end else begin
                                mtval           <= branch_target;
                                misaligned_trap <= 1'b1;
                                state           <= TRAP;
                            end
                        end else begin
                            pc <= pc_plus4;
`ifdef BRANCH_COUNTER_EN
                            retired_count <= retired_count + 32'd1;
`endif
                        end
                    end
                end
                TRAP: begin
                    if (trap_ack) begin
                        pc              <= TRAP_VECTOR;
                        misaligned_trap <= 1'b0;
                        state           <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_pc.sv
// Table-driven bench for unidad_pc with a queue scoreboard of expected results.
// Counter checks are active only when BRANCH_COUNTER_EN is defined.
module tb_unidad_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_pc_src;
    logic [31:0] branch_target;
    logic        pc_en;
    logic        trap_ack;
    logic [31:0] pc, pc_plus4, mtval;
    logic        misaligned_trap;
`ifdef BRANCH_COUNTER_EN
    logic [31:0] taken_count, retired_count;
`endif

    unidad_pc dut (
        .clk(clk), .rst(rst), .next_pc_src(next_pc_src), .branch_target(branch_target),
        .pc_en(pc_en), .trap_ack(trap_ack), .pc(pc), .pc_plus4(pc_plus4),
        .misaligned_trap(misaligned_trap), .mtval(mtval)
`ifdef BRANCH_COUNTER_EN
        , .taken_count(taken_count), .retired_count(retired_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        nps;
        logic [31:0] bt;
        logic        en;
        logic        ack;
        logic [31:0] e_pc;
        logic        e_trap;
        logic [31:0] e_mtval;
        logic [31:0] e_taken;
        logic [31:0] e_ret;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic nps, input logic [31:0] bt, input logic en,
                                input logic ack, input logic [31:0] e_pc, input logic e_trap,
                                input logic [31:0] e_mtval, input logic [31:0] e_taken,
                                input logic [31:0] e_ret);
        vec_t v;
        v.nps = nps; v.bt = bt; v.en = en; v.ack = ack;
        v.e_pc = e_pc; v.e_trap = e_trap; v.e_mtval = e_mtval;
        v.e_taken = e_taken; v.e_ret = e_ret;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".pc"}, pc, e.e_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, e.e_pc + 32'd4);
        chk({tag, ".trap"}, {31'h0, misaligned_trap}, {31'h0, e.e_trap});
        chk({tag, ".mtval"}, mtval, e.e_mtval);
`ifdef BRANCH_COUNTER_EN
        chk({tag, ".taken"}, taken_count, e.e_taken);
        chk({tag, ".retired"}, retired_count, e.e_ret);
`endif
    endtask

    // Drive one vector, let one rising edge pass, then compare the popped expectation.
    task automatic step(input vec_t v, input string tag);
        next_pc_src   = v.nps;
        branch_target = v.bt;
        pc_en         = v.en;
        trap_ack      = v.ack;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; next_pc_src = 1'b0; branch_target = 32'h0; pc_en = 1'b0; trap_ack = 1'b0;

        //            nps bt            en ack pc            trap mtval       tk ret
        tbl.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   0, 0));  // BOOT
        tbl.push_back(mk(0, 32'h0,         1, 0, 32'h4,         0, 32'h0,   0, 1));
        tbl.push_back(mk(0, 32'h0,         1, 0, 32'h8,         0, 32'h0,   0, 2));
        tbl.push_back(mk(0, 32'h0,         1, 0, 32'hC,         0, 32'h0,   0, 3));
        tbl.push_back(mk(0, 32'h0,         1, 0, 32'h10,        0, 32'h0,   0, 4));
        tbl.push_back(mk(1, 32'h200,       1, 0, 32'h200,       0, 32'h0,   1, 5));  // taken
        tbl.push_back(mk(1, 32'h300,       0, 0, 32'h200,       0, 32'h0,   1, 5));  // stall
        tbl.push_back(mk(0, 32'h0,         1, 1, 32'h204,       0, 32'h0,   1, 6));  // ack in RUN
        tbl.push_back(mk(1, 32'h20,        1, 0, 32'h20,        0, 32'h0,   2, 7));
        tbl.push_back(mk(1, 32'h302,       1, 0, 32'h20,        1, 32'h302, 2, 7));  // trap entry
        tbl.push_back(mk(1, 32'h400,       1, 0, 32'h20,        1, 32'h302, 2, 7));  // TRAP ignores
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h100,       0, 32'h302, 2, 7));  // ack beats stall
        tbl.push_back(mk(0, 32'h0,         1, 0, 32'h104,       0, 32'h302, 2, 8));
        tbl.push_back(mk(1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 32'h302, 3, 9));
        tbl.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h302, 3, 10)); // wrap
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 32'h500,   0, 0, 32'h0,         0, 32'h302, 3, 10));
        tbl.push_back(mk(1, 32'h302,       1, 0, 32'h0,         1, 32'h302, 3, 10)); // into TRAP

        // Reset state while rst is held.
        #2;
        sb.push_back(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
        check_outputs("reset");
        #10;   // release between edges (t=12)
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset between edges while a trap is pending.
        #3;
        rst = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
        check_outputs("async_rst");
        #2;
        rst = 1'b0;
        // BOOT holds pc on the first edge even with pc_en=1, then RUN advances.
        step(mk(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0, 0), "post_rst_boot");
        step(mk(0, 32'h0, 1, 0, 32'h4, 0, 32'h0, 0, 1), "post_rst_run");

        // Mid-stall reset: pc must return to the reset vector.
        step(mk(0, 32'h0, 0, 0, 32'h4, 0, 32'h0, 0, 1), "stall");
        #3;
        rst = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
        check_outputs("stall_rst");
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
